// File: rtl/lsu_bus_master.sv
// ============================================================================
//  Module   : lsu_bus_master
//  Purpose  : Load/store initiator from the CPU MEM stage to a word-wide,
//             byte-enabled data bus, with misalign detection and a watchdog.
//  Options  : LSU_STORE_TRACE_EN - print a trace line on every store ack
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_bus_master #(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ADDR_MASK = 32'h0000_3FFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [2:0]  cpu_op,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] cpu_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        resp_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [2:0] c_LW  = 3'd0;
    localparam logic [2:0] c_LH  = 3'd1;
    localparam logic [2:0] c_LB  = 3'd2;
    localparam logic [2:0] c_LHU = 3'd3;
    localparam logic [2:0] c_LBU = 3'd4;
    localparam logic [2:0] c_SW  = 3'd5;
    localparam logic [2:0] c_SH  = 3'd6;
    localparam logic [2:0] c_SB  = 3'd7;

    localparam int c_CNT_W = $clog2(TIMEOUT + 2);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [2:0]         r_op;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_pc;
    logic [31:0]        r_rdata;
    logic               r_misalign;
    logic               r_timeout;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_mis;
    logic               w_wdog;
    logic               w_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_lane;
    logic [31:0]        w_load;

    assign w_accept = cpu_valid && (r_state == c_IDLE);
    assign w_wdog   = (TIMEOUT != 0) && (r_cnt == c_CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_mis = 1'b0;
        case (cpu_op)
            c_LW, c_SW:        w_mis = (cpu_addr[1:0] != 2'b00);
            c_LH, c_LHU, c_SH: w_mis = cpu_addr[0];
            default:           w_mis = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; an ack in the watchdog's final cycle still wins
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_next = w_mis ? c_RESP : c_REQ;
            c_REQ:   if (bus_ack || w_wdog) w_next = c_RESP;
            c_RESP:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Latched access, watchdog count and completion status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_pc       <= 32'd0;
            r_rdata    <= 32'd0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_op       <= cpu_op;
                        r_addr     <= cpu_addr;
                        r_wdata    <= cpu_wdata;
                        r_pc       <= cpu_pc;
                        r_misalign <= w_mis;
                        r_timeout  <= 1'b0;
                        r_rdata    <= 32'd0;
                    end
                end
                c_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_ack)     r_rdata   <= w_load;
                    else if (w_wdog) r_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_we = (r_op == c_SW) || (r_op == c_SH) || (r_op == c_SB);

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'd0;
        case (r_op)
            c_SW: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
            c_SH: begin
                w_be    = 4'b0011 << r_addr[1:0];
                w_wdata = {2{r_wdata[15:0]}};
            end
            c_SB: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Addressed lane shifted down to bit 0, then extended by op
    assign w_lane = bus_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load = 32'd0;
        case (r_op)
            c_LW:    w_load = bus_rdata;
            c_LH:    w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            c_LHU:   w_load = {16'd0, w_lane[15:0]};
            c_LB:    w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            c_LBU:   w_load = {24'd0, w_lane[7:0]};
            default: w_load = 32'd0;
        endcase
    end

    // Outputs; bus fields read zero outside REQ
    always_comb begin
        cpu_ready     = (r_state == c_IDLE);
        bus_req       = (r_state == c_REQ);
        resp_valid    = (r_state == c_RESP);
        bus_we        = bus_req && w_we;
        bus_addr      = bus_req ? ({r_addr[31:2], 2'b00} & ADDR_MASK) : 32'd0;
        bus_be        = bus_req ? w_be : 4'b0000;
        bus_wdata     = bus_req ? w_wdata : 32'd0;
        resp_rdata    = resp_valid ? r_rdata : 32'd0;
        resp_misalign = resp_valid && r_misalign;
        resp_timeout  = resp_valid && r_timeout;
    end

`ifdef LSU_STORE_TRACE_EN
    logic [31:0] w_lane_mask;
    assign w_lane_mask = {{8{bus_be[3]}}, {8{bus_be[2]}}, {8{bus_be[1]}}, {8{bus_be[0]}}};

    always @(posedge clk) begin
        if (!rst && bus_req && bus_ack && bus_we)
            $display("@%h: *%h <= %h", r_pc, bus_addr, bus_wdata & w_lane_mask);
    end
`else
    // PC is latched for tracing only; fold it away when tracing is off
    logic w_unused_pc;
    assign w_unused_pc = ^r_pc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_master.sv
// ============================================================================
//  Module   : tb_lsu_bus_master
//  Purpose  : Self-checking bench for lsu_bus_master: directed cases plus
//             randomized accesses against a byte-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_bus_master;

    localparam int          c_TIMEOUT = 4;
    localparam logic [31:0] c_MASK    = 32'h0000_3FFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [2:0]  cpu_op;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        resp_timeout;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_bus_master #(.TIMEOUT(c_TIMEOUT), .ADDR_MASK(c_MASK)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_op(cpu_op),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_pc(cpu_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .resp_timeout(resp_timeout),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, store/sign attributes
    function automatic int op_size(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd5) return 4;
        if (op == 3'd1 || op == 3'd3 || op == 3'd6) return 2;
        return 1;
    endfunction

    function automatic bit op_store(input logic [2:0] op);
        return op >= 3'd5;
    endfunction

    function automatic bit op_misaligned(input logic [2:0] op, input logic [31:0] a);
        return (int'(a[1:0]) % op_size(op)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] a);
        logic [7:0] m;
        if (!op_store(op)) return 4'b0000;
        m = 8'((1 << op_size(op)) - 1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        if (!op_store(op)) return 32'd0;
        sz = op_size(op);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [63:0] v;
        int sz;
        if (op_store(op)) return 32'd0;
        sz = op_size(op);
        v  = ({32'd0, rd} >> (8 * int'(a[1:0]))) & ((64'd1 << (8 * sz)) - 1);
        if ((op == 3'd1 || op == 3'd2) && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    // One access starting at a negedge in IDLE; waits<0 means never ack
    task automatic access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                          input int waits, input logic [31:0] rd);
        chk("ready_before", {31'd0, cpu_ready}, 32'd1);
        cpu_valid = 1'b1;
        cpu_op    = op;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_pc    = $urandom;
        @(negedge clk);
        cpu_valid = 1'b0;
        cpu_op    = 3'($urandom);
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        if (op_misaligned(op, a)) begin
            chk("mis_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("mis_flag", {31'd0, resp_misalign}, 32'd1);
            chk("mis_rdata", resp_rdata, 32'd0);
            chk("mis_no_req", {31'd0, bus_req}, 32'd0);
            @(negedge clk);
            chk("mis_ready_after", {31'd0, cpu_ready}, 32'd1);
            return;
        end
        for (int k = 0; k < c_TIMEOUT; k++) begin
            chk("req_high", {31'd0, bus_req}, 32'd1);
            chk("req_we", {31'd0, bus_we}, {31'd0, op_store(op)});
            chk("req_addr", bus_addr, (a & ~32'd3) & c_MASK);
            chk("req_be", {28'd0, bus_be}, {28'd0, exp_be(op, a)});
            chk("req_wdata", bus_wdata, exp_wdata(op, d));
            chk("req_no_resp", {31'd0, resp_valid | cpu_ready}, 32'd0);
            bus_ack   = (k == waits);
            bus_rdata = (k == waits) ? rd : $urandom;
            @(negedge clk);
            bus_ack = 1'b0;
            if (k == waits) break;
        end
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_req_low", {31'd0, bus_req}, 32'd0);
        chk("resp_timeout", {31'd0, resp_timeout}, {31'd0, waits < 0});
        chk("resp_misalign", {31'd0, resp_misalign}, 32'd0);
        chk("resp_rdata", resp_rdata, (waits < 0) ? 32'd0 : exp_load(op, a, rd));
        if (waits < 0) bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("post_resp_low", {31'd0, resp_valid}, 32'd0);
        chk("post_req_low", {31'd0, bus_req}, 32'd0);
        chk("post_ready", {31'd0, cpu_ready}, 32'd1);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        int          w;

        rst       = 1'b1;
        cpu_valid = 1'b0;
        cpu_op    = 3'd0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        cpu_pc    = 32'd0;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_outs", {29'd0, resp_valid, bus_req, bus_we}, 32'd0);
        chk("rst_bus", bus_addr | bus_wdata | {28'd0, bus_be} | resp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        access(3'd2, 32'h0000_1003, 32'd0, 0, 32'h80FF_0000);
        access(3'd3, 32'h0000_0002, 32'd0, 3, 32'h8001_1234);
        access(3'd7, 32'h0000_0005, 32'h1234_56AB, 1, 32'd0);
        access(3'd5, 32'h0000_0006, 32'hDEAD_BEEF, 0, 32'd0);
        access(3'd0, 32'h0000_0040, 32'd0, -1, 32'd0);
        access(3'd1, 32'hFFFF_FFFE, 32'd0, 2, 32'h8765_4321);

        // Reset during the second REQ cycle drops the access silently
        cpu_valid = 1'b1;
        cpu_op    = 3'd0;
        cpu_addr  = 32'h0000_0100;
        @(negedge clk);
        cpu_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_req_low", {31'd0, bus_req}, 32'd0);
        chk("rstmid_ready", {31'd0, cpu_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rstmid_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            w  = $urandom_range(0, 4);
            if (w == 4) w = -1;
            access(op, a, $urandom, w, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
